// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 settings -- register indices, field ranges, exception codes and handler address.
package cp0_pkg;
    localparam logic [4:0] SRIdx = 5'd12;
    localparam logic [4:0] CauseIdx = 5'd13;
    localparam logic [4:0] EPCIdx = 5'd14;
    localparam logic [4:0] PRIdIdx = 5'd15;
    localparam int IMRangeHi = 15;
    localparam int IMRangeLo = 10;
    localparam int IPRangeHi = 15;
    localparam int IPRangeLo = 10;
    localparam int ExcCodeFieldRangeHi = 6;
    localparam int ExcCodeFieldRangeLo = 2;
    localparam logic [4:0] ExcCodeInt = 5'd0;
    localparam logic [4:0] ExcCodeAdEL = 5'd4;
    localparam logic [4:0] ExcCodeAdES = 5'd5;
    localparam logic [31:0] HandlerAddr = 32'h0000_4180;
    localparam logic [31:0] PRIdDefault = 32'h4448_5937;

    // Delay-slot instructions restart at the branch, one word earlier.
    function automatic logic [31:2] epc_of(input logic [31:0] pc, input logic bd);
        logic [31:0] t;
        t = bd ? pc - 32'd4 : pc;
        return t[31:2];
    endfunction
endpackage

// File: rtl/cp0_if.sv
// cp0_if: MEM-stage pipeline <-> CP0 signal bundle.
interface cp0_if;
    logic [4:0] A1;
    logic [4:0] A2;
    logic [31:0] DIn;
    logic WE;
    logic [31:0] PC_M;
    logic BD_M;
    logic [4:0] ExcCode_M;
    logic [5:0] HWInt;
    logic EXLClr;
    logic [31:0] DOut;
    logic Req;
    logic [31:0] EPC;
    logic [31:0] HandlerPC;

    modport master (
        output A1, A2, DIn, WE, PC_M, BD_M, ExcCode_M, HWInt, EXLClr,
        input DOut, Req, EPC, HandlerPC
    );
    modport slave (
        input A1, A2, DIn, WE, PC_M, BD_M, ExcCode_M, HWInt, EXLClr,
        output DOut, Req, EPC, HandlerPC
    );
endinterface

// File: rtl/cp0.sv
// cp0: MEM-stage exception/interrupt arbiter holding SR, Cause, EPC and PRId.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL = PRIdDefault,
    parameter logic [31:0] HANDLER_ADDR = HandlerAddr
) (
    input logic clk,
    input logic reset,
    cp0_if.slave bus
);
    logic [5:0] im_q, im_d, ip_q, ip_d;
    logic exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
    logic [4:0] exc_q, exc_d;
    logic [31:2] epc_q, epc_d;
    logic int_req, exc_req, req, sr_wr, epc_wr;

    always_comb begin
        int_req = (|(bus.HWInt & im_q)) & ie_q & ~exl_q;
        exc_req = (bus.ExcCode_M != ExcCodeInt) & ~exl_q;
        req = int_req | exc_req;
        // An eret owns SR for its cycle; a same-cycle SR write is dropped.
        sr_wr = bus.WE & (bus.A2 == SRIdx) & ~req & ~bus.EXLClr;
        epc_wr = bus.WE & (bus.A2 == EPCIdx) & ~req;
        exl_d = req ? 1'b1 : bus.EXLClr ? 1'b0 : sr_wr ? bus.DIn[1] : exl_q;
        im_d = sr_wr ? bus.DIn[IMRangeHi:IMRangeLo] : im_q;
        ie_d = sr_wr ? bus.DIn[0] : ie_q;
        exc_d = req ? (int_req ? ExcCodeInt : bus.ExcCode_M) : exc_q;
        bd_d = req ? bus.BD_M : bd_q;
        ip_d = bus.HWInt;
        epc_d = req ? epc_of(bus.PC_M, bus.BD_M) : epc_wr ? bus.DIn[31:2] : epc_q;
    end

    always_ff @(posedge clk) exl_q <= reset ? 1'b0 : exl_d;
    always_ff @(posedge clk) im_q <= reset ? '0 : im_d;
    always_ff @(posedge clk) ie_q <= reset ? 1'b0 : ie_d;
    always_ff @(posedge clk) exc_q <= reset ? '0 : exc_d;
    always_ff @(posedge clk) bd_q <= reset ? 1'b0 : bd_d;
    always_ff @(posedge clk) ip_q <= reset ? '0 : ip_d;
    always_ff @(posedge clk) epc_q <= reset ? '0 : epc_d;

    always_comb begin
        bus.DOut = bus.A1 == SRIdx ? {16'd0, im_q, 8'd0, exl_q, ie_q} :
                   bus.A1 == CauseIdx ? {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0} :
                   bus.A1 == EPCIdx ? {epc_q, 2'b00} :
                   bus.A1 == PRIdIdx ? PRID_VAL : 32'd0;
    end

    assign bus.Req = req;
    assign bus.EPC = {epc_q, 2'b00};
    assign bus.HandlerPC = HANDLER_ADDR;
endmodule

// File: tb/tb_cp0.sv
// tb_cp0: directed scenarios plus randomized traffic checked against a word-level CP0 model.
module tb_cp0;
    localparam logic [31:0] PRID = 32'h4448_5937;
    localparam logic [31:0] HADDR = 32'h0000_4180;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_sr, m_cause, m_epc;
    logic [31:0] v;

    cp0_if bus();
    cp0 #(.PRID_VAL(PRID), .HANDLER_ADDR(HADDR)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic m_int();
        return (|(bus.HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int() || ((bus.ExcCode_M != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        return idx == 5'd12 ? m_sr : idx == 5'd13 ? m_cause : idx == 5'd14 ? m_epc :
               idx == 5'd15 ? PRID : 32'd0;
    endfunction

    task automatic model_update();
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
        end else begin
            logic take, intr;
            intr = m_int();
            take = m_req();
            m_cause[15:10] = bus.HWInt;
            if (take) begin
                m_sr[1] = 1'b1;
                m_cause[6:2] = intr ? 5'd0 : bus.ExcCode_M;
                m_cause[31] = bus.BD_M;
                m_epc = (bus.BD_M ? bus.PC_M - 32'd4 : bus.PC_M) & 32'hFFFF_FFFC;
            end else begin
                if (bus.EXLClr) m_sr[1] = 1'b0;
                else if (bus.WE && bus.A2 == 5'd12) m_sr = bus.DIn & 32'h0000_FC03;
                if (bus.WE && bus.A2 == 5'd14) m_epc = bus.DIn & 32'hFFFF_FFFC;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] idx, output logic [31:0] d);
        bus.A1 = idx;
        #1;
        d = bus.DOut;
    endtask

    task automatic idle();
        bus.A1 = 0; bus.A2 = 0; bus.DIn = 0; bus.WE = 0; bus.PC_M = 0; bus.BD_M = 0;
        bus.ExcCode_M = 0; bus.HWInt = 0; bus.EXLClr = 0;
    endtask

    task automatic mtc0(input logic [4:0] idx, input logic [31:0] d);
        bus.WE = 1; bus.A2 = idx; bus.DIn = d;
        step();
        bus.WE = 0;
    endtask

    task automatic test_reset();
        idle();
        bus.HWInt = 6'h3F;
        reset = 1;
        step();
        reset = 0;
        #1;
        n_cmp++; if (bus.Req !== 1'b0) begin $display("FAIL reset_req got=%b exp=0", bus.Req); n_err++; end
        for (int i = 12; i <= 15; i++) begin
            rd(5'(i), v);
            n_cmp++;
            if (v !== (i == 15 ? PRID : 32'd0)) begin $display("FAIL reset_reg%0d got=%h exp=%h", i, v, i == 15 ? PRID : 32'd0); n_err++; end
        end
        n_cmp++; if (bus.HandlerPC !== HADDR) begin $display("FAIL handler_pc got=%h exp=%h", bus.HandlerPC, HADDR); n_err++; end
    endtask

    task automatic test_interrupt_entry();
        idle();
        mtc0(5'd12, 32'h0000_0401);
        bus.HWInt = 6'h01; bus.PC_M = 32'h3010; bus.BD_M = 0;
        #1;
        n_cmp++; if (bus.Req !== 1'b1) begin $display("FAIL int_req got=%b exp=1", bus.Req); n_err++; end
        step();
        n_cmp++; if (bus.Req !== 1'b0) begin $display("FAIL int_req_held got=%b exp=0", bus.Req); n_err++; end
        rd(5'd12, v);
        n_cmp++; if (v !== 32'h0000_0403) begin $display("FAIL int_sr got=%h exp=00000403", v); n_err++; end
        rd(5'd14, v);
        n_cmp++; if (v !== 32'h0000_3010) begin $display("FAIL int_epc got=%h exp=00003010", v); n_err++; end
        rd(5'd13, v);
        n_cmp++; if (v !== 32'h0000_0400) begin $display("FAIL int_cause got=%h exp=00000400", v); n_err++; end
    endtask

    task automatic test_delay_slot();
        idle();
        bus.EXLClr = 1;
        step();
        idle();
        bus.ExcCode_M = 5'd4; bus.BD_M = 1; bus.PC_M = 32'h3024;
        #1;
        n_cmp++; if (bus.Req !== 1'b1) begin $display("FAIL adel_req got=%b exp=1", bus.Req); n_err++; end
        step();
        idle();
        rd(5'd14, v);
        n_cmp++; if (v !== 32'h0000_3020) begin $display("FAIL adel_epc got=%h exp=00003020", v); n_err++; end
        rd(5'd13, v);
        n_cmp++; if (v !== 32'h8000_0010) begin $display("FAIL adel_cause got=%h exp=80000010", v); n_err++; end
    endtask

    task automatic test_simultaneous();
        idle();
        bus.EXLClr = 1;
        step();
        idle();
        mtc0(5'd12, 32'h0000_0801);
        bus.HWInt = 6'h02; bus.ExcCode_M = 5'd5; bus.PC_M = 32'h4000;
        bus.WE = 1; bus.A2 = 5'd14; bus.DIn = 32'h5000;
        #1;
        n_cmp++; if (bus.Req !== 1'b1) begin $display("FAIL sim_req got=%b exp=1", bus.Req); n_err++; end
        step();
        bus.WE = 0; bus.ExcCode_M = 0;
        rd(5'd13, v);
        n_cmp++; if (v !== 32'h0000_0800) begin $display("FAIL sim_cause got=%h exp=00000800", v); n_err++; end
        rd(5'd14, v);
        n_cmp++; if (v !== 32'h0000_4000) begin $display("FAIL sim_epc got=%h exp=00004000", v); n_err++; end
    endtask

    task automatic test_eret_reentry();
        bus.EXLClr = 1; bus.PC_M = 32'h4100;
        #1;
        n_cmp++; if (bus.Req !== 1'b0) begin $display("FAIL eret_req_before got=%b exp=0", bus.Req); n_err++; end
        step();
        bus.EXLClr = 0; bus.PC_M = 32'h4200;
        #1;
        n_cmp++; if (bus.Req !== 1'b1) begin $display("FAIL reentry_req got=%b exp=1", bus.Req); n_err++; end
        step();
        n_cmp++; if (bus.EPC !== 32'h0000_4200) begin $display("FAIL reentry_epc got=%h exp=00004200", bus.EPC); n_err++; end
        rd(5'd12, v);
        n_cmp++; if (v !== 32'h0000_0803) begin $display("FAIL reentry_sr got=%h exp=00000803", v); n_err++; end
    endtask

    task automatic test_masking();
        idle();
        bus.EXLClr = 1;
        step();
        idle();
        mtc0(5'd12, 32'h0000_FC00);
        bus.HWInt = 6'h07;
        #1;
        n_cmp++; if (bus.Req !== 1'b0) begin $display("FAIL mask_ie_req got=%b exp=0", bus.Req); n_err++; end
        step();
        rd(5'd13, v);
        n_cmp++; if (v !== 32'h0000_1C00) begin $display("FAIL mask_cause got=%h exp=00001c00", v); n_err++; end
        mtc0(5'd12, 32'h0000_0001);
        #1;
        n_cmp++; if (bus.Req !== 1'b0) begin $display("FAIL mask_im_req got=%b exp=0", bus.Req); n_err++; end
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, v);
        n_cmp++; if (v !== 32'h0000_1C00) begin $display("FAIL cause_write got=%h exp=00001c00", v); n_err++; end
        mtc0(5'd14, 32'h0000_3003);
        rd(5'd14, v);
        n_cmp++; if (v !== 32'h0000_3000) begin $display("FAIL epc_align got=%h exp=00003000", v); n_err++; end
    endtask

    task automatic test_random();
        logic [4:0] idx;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(63) == 0);
            bus.HWInt = 6'($urandom);
            bus.ExcCode_M = ($urandom_range(3) == 0) ? 5'($urandom) : 5'd0;
            bus.BD_M = 1'($urandom);
            bus.PC_M = $urandom & 32'hFFFF_FFFC;
            bus.WE = 1'($urandom);
            bus.A2 = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(15, 12));
            bus.DIn = $urandom;
            bus.EXLClr = ($urandom_range(7) == 0);
            idx = 5'($urandom_range(17, 10));
            rd(idx, v);
            n_cmp++; if (bus.Req !== m_req()) begin $display("FAIL rand_req cyc=%0d got=%b exp=%b", i, bus.Req, m_req()); n_err++; end
            n_cmp++; if (v !== m_read(idx)) begin $display("FAIL rand_dout cyc=%0d idx=%0d got=%h exp=%h", i, idx, v, m_read(idx)); n_err++; end
            n_cmp++; if (bus.EPC !== m_epc) begin $display("FAIL rand_epc cyc=%0d got=%h exp=%h", i, bus.EPC, m_epc); n_err++; end
            step();
        end
        reset = 0;
    endtask

    initial begin
        m_sr = 0; m_cause = 0; m_epc = 0;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_interrupt_entry();
        test_delay_slot();
        test_simultaneous();
        test_eret_reentry();
        test_masking();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
